// File: rtl/rr_mux_feeder_pkg.sv
// rr_mux_feeder_pkg: shared channel constants and arbiter state type for rr_mux_feeder
package rr_mux_feeder_pkg;
    localparam int N_CH = 4;
    localparam int SEL_W = 2;
    localparam int DEFAULT_DATA_W = 16;
    typedef enum logic {ST_IDLE, ST_OFFER} state_t;
endpackage

// File: rtl/rr_mux_feeder_pick4.sv
// rr_pick4: first eligible requester searching ptr, ptr+1, ... mod 4 with masked channels skipped
module rr_pick4
    import rr_mux_feeder_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    input  logic [N_CH-1:0]  mask,
    output logic             found,
    output logic [SEL_W-1:0] idx
);
    logic [N_CH-1:0]  elig;
    logic [SEL_W-1:0] c;
    assign elig = req & ~mask;
    // scan from the farthest offset down so the last hit is the one nearest ptr
    always_comb begin
        found = 1'b0;
        idx = ptr;
        c = ptr;
        for (int i = N_CH - 1; i >= 0; i--) begin
            c = ptr + SEL_W'(i);
            if (elig[c]) begin
                found = 1'b1;
                idx = c;
            end
        end
    end
endmodule

// File: rtl/rr_mux_feeder.sv
// rr_mux_feeder: one-deep per-channel buffers feeding a 4:1 mux, round-robin select; RR_MUX_FEEDER_STATS_EN adds grant counters
module rr_mux_feeder
    import rr_mux_feeder_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
`ifdef RR_MUX_FEEDER_STATS_EN
    , parameter int CNT_W = 16
`endif
)(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_CH-1:0]   i_valid,
    input  logic [DATA_W-1:0] i_data_0,
    input  logic [DATA_W-1:0] i_data_1,
    input  logic [DATA_W-1:0] i_data_2,
    input  logic [DATA_W-1:0] i_data_3,
    output logic [N_CH-1:0]   o_ready,
    output logic [SEL_W-1:0]  o_ctrl,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data_0,
    output logic [DATA_W-1:0] o_data_1,
    output logic [DATA_W-1:0] o_data_2,
    output logic [DATA_W-1:0] o_data_3
`ifdef RR_MUX_FEEDER_STATS_EN
    , output logic [N_CH*CNT_W-1:0] o_grant_cnt
`endif
);
    state_t            state, state_n;
    logic [SEL_W-1:0]  ctrl, ctrl_n, ptr, ptr_n, pick_ptr, pick_idx;
    logic [N_CH-1:0]   buf_full, buf_full_n, pick_mask, wr, sel_oh;
    logic              pick_found, drain;
    logic [DATA_W-1:0] din [N_CH];
    logic [DATA_W-1:0] buf_data [N_CH];

    assign din[0] = i_data_0;
    assign din[1] = i_data_1;
    assign din[2] = i_data_2;
    assign din[3] = i_data_3;
    assign o_data_0 = buf_data[0];
    assign o_data_1 = buf_data[1];
    assign o_data_2 = buf_data[2];
    assign o_data_3 = buf_data[3];

    assign o_valid = state == ST_OFFER;
    assign o_ctrl = ctrl;
    assign drain = o_valid && i_ready;
    assign sel_oh = N_CH'(1) << ctrl;
    assign o_ready = ~buf_full | (drain ? sel_oh : '0);
    assign wr = i_valid & o_ready;
    assign buf_full_n = (buf_full & ~(drain ? sel_oh : '0)) | wr;
    // while offering, the next pick starts after the current channel and excludes it
    assign pick_ptr = o_valid ? ctrl + 2'd1 : ptr;
    assign pick_mask = o_valid ? sel_oh : '0;

    rr_pick4 u_pick (
        .req   (buf_full),
        .ptr   (pick_ptr),
        .mask  (pick_mask),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // arbiter next state: start an offer from idle, or chain the next offer on a drain
    always_comb begin
        state_n = state;
        ctrl_n = ctrl;
        ptr_n = ptr;
        if (state == ST_IDLE && pick_found) begin
            state_n = ST_OFFER;
            ctrl_n = pick_idx;
        end
        if (drain) begin
            state_n = pick_found ? ST_OFFER : ST_IDLE;
            ctrl_n = pick_found ? pick_idx : ctrl;
            ptr_n = pick_ptr;
        end
    end

    // arbiter and buffer-occupancy registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            ctrl <= '0;
            ptr <= '0;
            buf_full <= '0;
        end else begin
            state <= state_n;
            ctrl <= ctrl_n;
            ptr <= ptr_n;
            buf_full <= buf_full_n;
        end
    end

    // buffer words change only when their channel is written
    always_ff @(posedge i_clk) begin
        for (int n = 0; n < N_CH; n++) begin
            if (i_rst) buf_data[n] <= '0;
            else if (wr[n]) buf_data[n] <= din[n];
        end
    end

`ifdef RR_MUX_FEEDER_STATS_EN
    logic [CNT_W-1:0] cnt [N_CH];

    // saturating count of accepted transfers per channel
    always_ff @(posedge i_clk) begin
        for (int n = 0; n < N_CH; n++) begin
            if (i_rst) cnt[n] <= '0;
            else if (drain && ctrl == SEL_W'(n) && cnt[n] != '1) cnt[n] <= cnt[n] + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_cnt
        assign o_grant_cnt[g*CNT_W +: CNT_W] = cnt[g];
    end
`endif
endmodule
